mmio_gpio_timer: RTL and testbench
==================================

# mmio_gpio_timer

Memory-mapped I/O responder on the processor's data-memory port: it serves loads and stores that fall in a fixed 64-byte address window and owns the board switches, LEDs and a compare timer. The data-memory block instantiates it, forwards `Addres`, `memWr`, `memRd` and `datawr` to it, and selects its `datard` whenever `hit` is high. Reads are combinational, matching the single-cycle datapath. Writes commit on the rising edge of `clk`.

## Interface
Parameters:
- `BASE`, 13'h1FC0: window base; must be 64-byte aligned. Match when `Addres[12:6] == BASE[12:6]`.
- `DEB_CYCLES`, 4: number of consecutive stable synchronized samples needed before a switch change is accepted (range 1–255).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `Addres` in 13: byte address from the ALU.
- `memWr` in 1: store strobe.
- `memRd` in 1: load strobe.
- `datawr` in 64: store data.
- `sw` in 8: raw asynchronous switches.
- `datard` out 64: load data; 0 when not (`memRd` & `hit`).
- `hit` out 1: combinational; `Addres` is inside the window.
- `leds` out 8: LED register.
- `irq` out 1: registered interrupt request.

## Operation
Register offset is `Addres[5:3]`; `Addres[2:0]` is ignored. Every read value is zero-extended to 64 bits.
- 0 LEDS, RW, bits [7:0]: drives `leds`.
- 1 SWITCH, RO: debounced switch state.
- 2 STATUS, W1C: [7:0] rising-edge flags per switch, [8] timer match flag.
- 3 CTRL, RW: [0] timer enable, [1] irq enable, [2] edge-irq enable.
- 4 TIMER, RW, 32 bits: a write loads the counter.
- 5 CMP, RW, 32 bits.
- 6 and 7: read 0; writes are ignored.

Write behaviour:
- Writes require `memWr & hit`.
- If `memWr` and `memRd` are both high, the read returns the pre-edge value and the write commits at the edge.

Switch path, per bit:
- Two-flop synchronizer, then the debouncer.
- The debounce counter increments while the synchronized value differs from the debounced value, and clears when they match.
- When the count reaches `DEB_CYCLES`, the debounced bit takes the synchronized value and the counter clears.
- A 0→1 change of a debounced bit sets its STATUS bit.

Timer:
- While CTRL[0] is set, TIMER increments every cycle.
- When TIMER == CMP, the next value is 0 (wrap) and STATUS[8] is set.
- TIMER also wraps naturally from 32'hFFFF_FFFF to 0 with no flag.

Interrupt:
- `irq` next value = (CTRL[1] & STATUS[8]) | (CTRL[2] & |STATUS[7:0]).

Conflicts:
- A set event beats a W1C clear on the same bit in the same cycle.
- A TIMER write beats increment and wrap.
- A CMP write takes effect for the comparison on the next cycle.

## Timing
- Reset values: `leds`=0, SWITCH=0, STATUS=0, CTRL=0, TIMER=0, CMP=32'hFFFF_FFFF, `irq`=0, synchronizers=0, debounce counters=0. `datard` and `hit` are combinational.
- `rst` asserted mid-debounce or while counting clears all state on the next edge. Writes in the reset cycle are dropped.
- Read latency is 0 cycles. Write visibility: readable the cycle after the edge.
- Switch latency: a clean step on `sw` appears in SWITCH after 2 + `DEB_CYCLES` edges. The STATUS edge flag appears on the same edge. `irq` follows one edge later.
- A glitch shorter than `DEB_CYCLES` synchronized cycles is never accepted.
- Timer: with CMP=N and the enable written at edge 0, STATUS[8] sets at the edge where TIMER would pass N, which is edge N+1. Period is N+1 cycles.

## Structure
- Package `mmio_pkg` holds:
  - register offset constants (`OFF_LEDS`…`OFF_CMP`);
  - the CTRL bit indices;
  - the STATUS timer bit index;
  - the CMP reset value.
- Sub-module `sw_debounce`: one bit, containing the synchronizer, counter and debounced flop. It is instantiated 8 times in a generate loop.
- The top contains address decode, the register file, the timer, the read mux and the irq flop. Expected size is about 200 lines.

## Test plan
- Reset: drive `rst` for 2 cycles. After release, reads of all six registers return 0, 0, 0, 0, 0 and 32'hFFFF_FFFF, and `leds`=0 and `irq`=0.
- Decode: store 64'hFFA5 to BASE+0. Then `leds`=8'hA5, and a read at BASE+0 returns 64'hA5. A store to BASE+64 leaves `leds` unchanged with `hit`=0. A load at BASE+0x30 returns 0.
- Debounce: with `DEB_CYCLES`=4, raise `sw[3]` for 3 cycles then drop it; SWITCH stays 0. Hold `sw[3]` high; SWITCH reads 8'h08 after 6 edges and STATUS[3] is set.
- W1C race: arrange STATUS[3]=1 with a new `sw[5]` edge landing on the same edge as a write of 9'h028 to STATUS. Result: STATUS = 9'h020; bit 5's set wins over its clear.
- Timer: write CMP=3, then CTRL=3'b011. STATUS[8] sets after 4 cycles and TIMER reads 0, then 1. `irq` goes high one edge after STATUS[8]. Writing 9'h100 to STATUS drops `irq` on the following edge.
- Reset mid-operation: assert `rst` while TIMER=2 and a debounce count is partial. Everything returns to reset values, and `sw` held high is re-accepted only after the full 2 + `DEB_CYCLES` edges.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared register map and bit positions for the MMIO GPIO/timer responder.
package mmio_pkg;

    typedef enum logic [2:0] {
        OFF_LEDS   = 3'd0,
        OFF_SWITCH = 3'd1,
        OFF_STATUS = 3'd2,
        OFF_CTRL   = 3'd3,
        OFF_TIMER  = 3'd4,
        OFF_CMP    = 3'd5,
        OFF_RSVD6  = 3'd6,
        OFF_RSVD7  = 3'd7
    } reg_off_e;

    localparam int unsigned CTRL_TMR_EN      = 0;
    localparam int unsigned CTRL_IRQ_EN      = 1;
    localparam int unsigned CTRL_EDGE_IRQ_EN = 2;

    localparam int unsigned STATUS_TMR_BIT = 8;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    localparam int unsigned DEB_CNT_W = 8;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchronizer followed by a stability-count debouncer.
module sw_debounce
    import mmio_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_async,
    output logic deb,
    output logic rise
);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 deb_q, deb_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = sw_async;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Flip on the edge that would bring the count up to DEB_CYCLES.
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_CNT_W'(DEB_CYCLES - 1)) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb  = deb_q;
    assign rise = deb_d & ~deb_q;

endmodule

// File: rtl/mmio_gpio_timer.sv
// MMIO responder for a 64-byte window: LEDs, debounced switches with edge
// flags, a compare timer and a level interrupt.
module mmio_gpio_timer
    import mmio_pkg::*;
#(
    parameter logic [12:0] BASE       = 13'h1FC0,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] Addres,
    input  logic        memWr,
    input  logic        memRd,
    input  logic [63:0] datawr,
    input  logic [7:0]  sw,
    output logic [63:0] datard,
    output logic        hit,
    output logic [7:0]  leds,
    output logic        irq
);

    logic [7:0]  leds_q, leds_d;
    logic [8:0]  status_q, status_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;

    logic [7:0]  sw_deb;
    logic [7:0]  sw_rise;
    logic [8:0]  status_set, status_clr;
    logic        tmr_match;
    logic        wr_en;
    reg_off_e    off;
    logic [63:0] rd_val;
    logic        unused_bits;

    assign hit         = (Addres[12:6] == BASE[12:6]);
    assign off         = reg_off_e'(Addres[5:3]);
    assign wr_en       = memWr & hit;
    assign unused_bits = ^{Addres[2:0], datawr[63:32]};

    for (genvar i = 0; i < 8; i++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .sw_async (sw[i]),
            .deb      (sw_deb[i]),
            .rise     (sw_rise[i])
        );
    end

    always_comb begin
        leds_d     = leds_q;
        ctrl_d     = ctrl_q;
        cmp_d      = cmp_q;
        timer_d    = timer_q;
        status_clr = '0;
        tmr_match  = 1'b0;

        if (ctrl_q[CTRL_TMR_EN]) begin
            if (timer_q == cmp_q) begin
                timer_d   = '0;
                tmr_match = 1'b1;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end

        // Register writes come last so a TIMER store overrides the count.
        if (wr_en) begin
            case (off)
                OFF_LEDS:   leds_d     = datawr[7:0];
                OFF_STATUS: status_clr = datawr[8:0];
                OFF_CTRL:   ctrl_d     = datawr[2:0];
                OFF_TIMER:  timer_d    = datawr[31:0];
                OFF_CMP:    cmp_d      = datawr[31:0];
                default:    ;
            endcase
        end

        status_set = {tmr_match, sw_rise};
        status_d   = (status_q & ~status_clr) | status_set;

        irq_d = (ctrl_q[CTRL_IRQ_EN] & status_q[STATUS_TMR_BIT])
              | (ctrl_q[CTRL_EDGE_IRQ_EN] & (|status_q[7:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q   <= '0;
            status_q <= '0;
            ctrl_q   <= '0;
            timer_q  <= '0;
            cmp_q    <= CMP_RESET;
            irq_q    <= 1'b0;
        end else begin
            leds_q   <= leds_d;
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_LEDS:   rd_val = {56'd0, leds_q};
            OFF_SWITCH: rd_val = {56'd0, sw_deb};
            OFF_STATUS: rd_val = {55'd0, status_q};
            OFF_CTRL:   rd_val = {61'd0, ctrl_q};
            OFF_TIMER:  rd_val = {32'd0, timer_q};
            OFF_CMP:    rd_val = {32'd0, cmp_q};
            default:    rd_val = '0;
        endcase
        datard = (memRd & hit) ? rd_val : '0;
    end

    assign leds = leds_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_mmio_gpio_timer.sv
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_mmio_gpio_timer;

    localparam logic [12:0] BASE = 13'h1FC0;
    localparam int          DEB  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] Addres;
    logic        memWr;
    logic        memRd;
    logic [63:0] datawr;
    logic [7:0]  sw;
    logic [63:0] datard;
    logic        hit;
    logic [7:0]  leds;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mmio_gpio_timer #(
        .BASE       (BASE),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Addres (Addres),
        .memWr  (memWr),
        .memRd  (memRd),
        .datawr (datawr),
        .sw     (sw),
        .datard (datard),
        .hit    (hit),
        .leds   (leds),
        .irq    (irq)
    );

    // Reference model state
    logic [7:0]  m_leds;
    logic [7:0]  m_deb;
    logic [8:0]  m_status;
    logic [2:0]  m_ctrl;
    logic [31:0] m_timer;
    logic [31:0] m_cmp;
    logic        m_irq;
    logic [7:0]  m_pipe [2];
    int          m_run  [8];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_leds   = '0;
        m_deb    = '0;
        m_status = '0;
        m_ctrl   = '0;
        m_timer  = '0;
        m_cmp    = 32'hFFFF_FFFF;
        m_irq    = 1'b0;
        m_pipe[0] = '0;
        m_pipe[1] = '0;
        for (int b = 0; b < 8; b++) m_run[b] = 0;
    endtask

    function automatic logic in_window(input logic [12:0] a);
        return a[12:6] == BASE[12:6];
    endfunction

    function automatic logic [63:0] m_read(input logic [12:0] a, input logic rd);
        if (!(rd && in_window(a))) return 64'd0;
        case (int'(a[5:3]))
            0:       return 64'(m_leds);
            1:       return 64'(m_deb);
            2:       return 64'(m_status);
            3:       return 64'(m_ctrl);
            4:       return 64'(m_timer);
            5:       return 64'(m_cmp);
            default: return 64'd0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic [7:0] synced;
        logic [7:0] rise;
        logic [8:0] clr;
        logic       match;
        logic       wsel;
        logic       nirq;
        int         off;
        if (rst) begin
            model_reset();
            return;
        end
        synced = m_pipe[1];
        rise   = '0;
        for (int b = 0; b < 8; b++) begin
            if (synced[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_run[b] = 0;
                    m_deb[b] = synced[b];
                    rise[b]  = synced[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = sw;

        nirq  = (m_ctrl[1] && m_status[8]) || (m_ctrl[2] && (m_status[7:0] != 0));
        wsel  = memWr && in_window(Addres);
        off   = int'(Addres[5:3]);
        match = 1'b0;
        if (wsel && off == 4) begin
            m_timer = datawr[31:0];
        end else if (m_ctrl[0]) begin
            if (m_timer == m_cmp) begin
                m_timer = 0;
                match   = 1'b1;
            end else begin
                m_timer = m_timer + 1;
            end
        end
        clr      = (wsel && off == 2) ? datawr[8:0] : 9'd0;
        m_status = (m_status & ~clr) | {match, rise};
        if (wsel && off == 0) m_leds = datawr[7:0];
        if (wsel && off == 3) m_ctrl = datawr[2:0];
        if (wsel && off == 5) m_cmp  = datawr[31:0];
        m_irq = nirq;
    endtask

    task automatic step();
        #1;
        check_eq("hit", 64'(hit), 64'(in_window(Addres)));
        check_eq("datard", datard, m_read(Addres, memRd));
        @(posedge clk);
        model_edge();
        #1;
        check_eq("leds", 64'(leds), 64'(m_leds));
        check_eq("irq", 64'(irq), 64'(m_irq));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr_reg(input int off, input logic [63:0] d);
        Addres = BASE + 13'(off * 8);
        memWr  = 1'b1;
        memRd  = 1'b0;
        datawr = d;
        step();
        memWr  = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input int off, input logic [63:0] exp);
        Addres = BASE + 13'(off * 8);
        memWr  = 1'b0;
        memRd  = 1'b1;
        #1;
        check_eq(tag, datard, exp);
        step();
        memRd  = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        Addres = '0;
        memWr  = 1'b0;
        memRd  = 1'b0;
        datawr = '0;
        sw     = '0;
        model_reset();

        // Reset values
        idle(2);
        rst = 1'b0;
        rd_reg("rst_leds",   0, 64'd0);
        rd_reg("rst_switch", 1, 64'd0);
        rd_reg("rst_status", 2, 64'd0);
        rd_reg("rst_ctrl",   3, 64'd0);
        rd_reg("rst_timer",  4, 64'd0);
        rd_reg("rst_cmp",    5, 64'h0000_0000_FFFF_FFFF);
        check_eq("rst_irq", 64'(irq), 64'd0);

        // Decode
        wr_reg(0, 64'hFFA5);
        check_eq("leds_a5", 64'(leds), 64'hA5);
        rd_reg("rd_leds", 0, 64'hA5);
        Addres = BASE + 13'd64;
        memWr  = 1'b1;
        datawr = 64'h5A;
        #1;
        check_eq("miss_hit", 64'(hit), 64'd0);
        step();
        memWr = 1'b0;
        check_eq("miss_leds", 64'(leds), 64'hA5);
        rd_reg("rsvd6", 6, 64'd0);

        // Debounce: short glitch rejected, then a clean step accepted
        sw = 8'h08;
        idle(3);
        sw = 8'h00;
        idle(8);
        rd_reg("glitch_sw", 1, 64'd0);
        sw = 8'h08;
        idle(5);
        rd_reg("deb_early", 1, 64'd0);
        rd_reg("deb_sw", 1, 64'h08);
        rd_reg("deb_status", 2, 64'h008);

        // W1C race: bit 5 set lands with a clear of bits 3 and 5
        sw = 8'h28;
        idle(5);
        wr_reg(2, 64'h028);
        rd_reg("w1c_race", 2, 64'h020);
        wr_reg(2, 64'h020);

        // Timer with CMP=3 and irq enabled
        wr_reg(5, 64'd3);
        wr_reg(3, 64'h3);
        idle(3);
        rd_reg("tmr_3", 4, 64'd3);
        check_eq("irq_lag", 64'(irq), 64'd0);
        rd_reg("tmr_wrap", 4, 64'd0);
        check_eq("irq_set", 64'(irq), 64'd1);
        rd_reg("tmr_1", 4, 64'd1);
        wr_reg(2, 64'h100);
        check_eq("irq_hold", 64'(irq), 64'd1);
        step();
        check_eq("irq_drop", 64'(irq), 64'd0);
        rd_reg("tmr_reset_flag", 2, 64'h100);
        wr_reg(3, 64'h0);
        wr_reg(2, 64'h100);

        // Reset mid-operation
        sw = 8'h29;
        wr_reg(4, 64'd0);
        wr_reg(3, 64'h1);
        step();
        rd_reg("tmr_pre_rst", 4, 64'd1);
        rst    = 1'b1;
        Addres = BASE;
        memWr  = 1'b1;
        datawr = 64'hFF;
        step();
        rst   = 1'b0;
        memWr = 1'b0;
        check_eq("rst_drop_wr", 64'(leds), 64'd0);
        rd_reg("post_timer",  4, 64'd0);
        rd_reg("post_cmp",    5, 64'h0000_0000_FFFF_FFFF);
        rd_reg("post_ctrl",   3, 64'd0);
        rd_reg("post_status", 2, 64'd0);
        step();
        rd_reg("post_sw_early", 1, 64'd0);
        rd_reg("post_sw",       1, 64'h29);
        rd_reg("post_status2",  2, 64'h029);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) Addres = 13'($urandom);
            else Addres = {BASE[12:6], 6'($urandom)};
            memWr  = ($urandom_range(0, 3) == 0);
            memRd  = $urandom_range(0, 1) != 0;
            datawr = {$urandom, $urandom};
            if (Addres[5:3] == 3'd4 || Addres[5:3] == 3'd5)
                datawr[31:0] = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0)
                sw[$urandom_range(0, 7)] = ~sw[$urandom_range(0, 7)];
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
